// File: rtl/comms_pkg.sv
// ============================================================================
// comms_pkg : shared header-field constants, packet types and RX FSM states
// Revision  : 1.0
// ============================================================================
`default_nettype none

package comms_pkg;

  localparam int HDR_TYPE_BIT = 15;
  localparam int HDR_LEN_MSB  = 7;
  localparam int HDR_LEN_LSB  = 0;

  localparam logic PKT_CTRL = 1'b1;
  localparam logic PKT_DATA = 1'b0;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_FILL  = 3'd1,
    RX_DROP  = 3'd2,
    RX_READY = 3'd3,
    RX_HELD  = 3'd4
  } rx_state_t;

  function automatic logic [7:0] hdr_len(input logic [15:0] w);
    return w[HDR_LEN_MSB:HDR_LEN_LSB];
  endfunction

  function automatic logic hdr_type(input logic [15:0] w);
    return w[HDR_TYPE_BIT];
  endfunction

endpackage

`default_nettype wire

// File: rtl/comms_fifo.sv
// ============================================================================
// comms_fifo : synchronous show-ahead FIFO, push accepted when full if a pop
//              happens in the same cycle
// Revision   : 1.0
// ============================================================================
`default_nettype none

module comms_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             push_ok;
  logic             pop_ok;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_ok) wr_d = wr_q + 1'b1;
    if (pop_ok)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_q[AW-1:0]] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/comms_gpp_port.sv
// ============================================================================
// comms_gpp_port : comms-processor endpoint of the GPP link; one-packet RX
//                  buffer gated by rtr strobes, framed TX FIFO to the network
// Revision       : 1.0
// ============================================================================
`default_nettype none

module comms_gpp_port
  import comms_pkg::*;
#(
  parameter int RX_DEPTH = 64,
  parameter int TX_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable_rtr,
  input  logic                        gpp_rtr_cp,
  input  logic                        gpp_rtr_dp,
  input  logic                        gpp_trf_dp,
  input  logic [15:0]                 gpp_tx_data,
  input  logic [$clog2(RX_DEPTH)-1:0] gpp_rx_addr,
  output logic [15:0]                 RAM_rx_data_out,
  output logic                        data_rx_flag,
  output logic                        gpp_trf_cp,
  input  logic                        net_rx_valid,
  input  logic [15:0]                 net_rx_data,
  output logic                        net_rx_ready,
  output logic                        net_tx_valid,
  output logic [15:0]                 net_tx_data,
  output logic                        net_tx_last,
  input  logic                        net_tx_ready,
  output logic                        rx_err,
  output logic                        tx_overflow
);

  localparam int RX_AW = $clog2(RX_DEPTH);

  rx_state_t         rx_state_q, rx_state_d;
  logic              rx_type_q, rx_type_d;
  logic [7:0]        rx_len_q, rx_len_d;
  logic [7:0]        rx_idx_q, rx_idx_d;
  logic              rx_err_q, rx_err_d;
  logic              run_q;
  logic              rx_hs;
  logic              ram_we;
  logic [RX_AW-1:0]  ram_waddr;
  logic [15:0]       rx_ram [RX_DEPTH];

  // run_q keeps net_rx_ready low until the first edge after reset release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
      rx_type_q  <= PKT_DATA;
      rx_len_q   <= '0;
      rx_idx_q   <= '0;
      rx_err_q   <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_type_q  <= rx_type_d;
      rx_len_q   <= rx_len_d;
      rx_idx_q   <= rx_idx_d;
      rx_err_q   <= rx_err_d;
      run_q      <= 1'b1;
    end
  end

  assign net_rx_ready = run_q && ((rx_state_q == RX_IDLE) || (rx_state_q == RX_FILL) ||
                                  (rx_state_q == RX_DROP));
  assign rx_hs        = net_rx_valid && net_rx_ready;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_type_d  = rx_type_q;
    rx_len_d   = rx_len_q;
    rx_idx_d   = rx_idx_q;
    rx_err_d   = rx_err_q;
    ram_we     = 1'b0;
    ram_waddr  = '0;
    case (rx_state_q)
      RX_IDLE: if (rx_hs) begin
        ram_we    = 1'b1;
        rx_type_d = hdr_type(net_rx_data);
        rx_len_d  = hdr_len(net_rx_data);
        rx_idx_d  = 8'd1;
        if (hdr_len(net_rx_data) == 8'd0) begin
          rx_state_d = RX_READY;
        end else if (int'(hdr_len(net_rx_data)) > RX_DEPTH - 1) begin
          rx_state_d = RX_DROP;
          rx_err_d   = 1'b1;
        end else begin
          rx_state_d = RX_FILL;
        end
      end
      RX_FILL: if (rx_hs) begin
        ram_we    = 1'b1;
        ram_waddr = RX_AW'(rx_idx_q);
        if (rx_idx_q == rx_len_q) rx_state_d = RX_READY;
        else                      rx_idx_d   = rx_idx_q + 8'd1;
      end
      RX_DROP: if (rx_hs) begin
        if (rx_idx_q == rx_len_q) rx_state_d = RX_IDLE;
        else                      rx_idx_d   = rx_idx_q + 8'd1;
      end
      RX_READY: begin
        if (enable_rtr && ((rx_type_q == PKT_CTRL) ? gpp_rtr_cp : gpp_rtr_dp))
          rx_state_d = RX_HELD;
      end
      RX_HELD: begin
        if (!enable_rtr) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ram_we) rx_ram[ram_waddr] <= net_rx_data;
  end

  assign data_rx_flag    = (rx_state_q == RX_HELD);
  assign gpp_trf_cp      = data_rx_flag && rx_type_q;
  assign RAM_rx_data_out = data_rx_flag ? rx_ram[gpp_rx_addr] : 16'h0000;
  assign rx_err          = rx_err_q;

  logic        tx_full, tx_empty, tx_pop;
  logic [15:0] tx_head;
  logic        tx_hdr_q, tx_hdr_d;
  logic [7:0]  tx_rem_q, tx_rem_d;
  logic        tx_ovf_q, tx_ovf_d;

  comms_fifo #(
    .WIDTH (16),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (gpp_trf_dp),
    .din   (gpp_tx_data),
    .pop   (tx_pop),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty)
  );

  assign net_tx_valid = !tx_empty;
  assign tx_pop       = net_tx_valid && net_tx_ready;
  assign net_tx_data  = net_tx_valid ? tx_head : 16'h0000;
  assign net_tx_last  = net_tx_valid &&
                        (tx_hdr_q ? (hdr_len(tx_head) == 8'd0) : (tx_rem_q == 8'd1));
  assign tx_overflow  = tx_ovf_q;

  always_comb begin
    tx_hdr_d = tx_hdr_q;
    tx_rem_d = tx_rem_q;
    tx_ovf_d = tx_ovf_q | (gpp_trf_dp && tx_full && !tx_pop);
    if (tx_pop) begin
      if (tx_hdr_q) begin
        if (hdr_len(tx_head) != 8'd0) begin
          tx_hdr_d = 1'b0;
          tx_rem_d = hdr_len(tx_head);
        end
      end else begin
        tx_rem_d = tx_rem_q - 8'd1;
        if (tx_rem_q == 8'd1) tx_hdr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_hdr_q <= 1'b1;
      tx_rem_q <= '0;
      tx_ovf_q <= 1'b0;
    end else begin
      tx_hdr_q <= tx_hdr_d;
      tx_rem_q <= tx_rem_d;
      tx_ovf_q <= tx_ovf_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_comms_gpp_port.sv
// ============================================================================
// tb_comms_gpp_port : directed + randomized bench for comms_gpp_port
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_comms_gpp_port;

  localparam int RX_DEPTH = 64;
  localparam int TX_DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable_rtr = 1'b0, gpp_rtr_cp = 1'b0, gpp_rtr_dp = 1'b0;
  logic        gpp_trf_dp = 1'b0;
  logic [15:0] gpp_tx_data = '0;
  logic [5:0]  gpp_rx_addr = '0;
  logic [15:0] RAM_rx_data_out;
  logic        data_rx_flag, gpp_trf_cp;
  logic        net_rx_valid = 1'b0;
  logic [15:0] net_rx_data = '0;
  logic        net_rx_ready;
  logic        net_tx_valid, net_tx_last;
  logic [15:0] net_tx_data;
  logic        net_tx_ready = 1'b0;
  logic        rx_err, tx_overflow;

  int checks = 0;
  int errors = 0;

  comms_gpp_port #(.RX_DEPTH(RX_DEPTH), .TX_DEPTH(TX_DEPTH)) dut (
    .clk(clk), .rst(rst), .enable_rtr(enable_rtr), .gpp_rtr_cp(gpp_rtr_cp),
    .gpp_rtr_dp(gpp_rtr_dp), .gpp_trf_dp(gpp_trf_dp), .gpp_tx_data(gpp_tx_data),
    .gpp_rx_addr(gpp_rx_addr), .RAM_rx_data_out(RAM_rx_data_out),
    .data_rx_flag(data_rx_flag), .gpp_trf_cp(gpp_trf_cp),
    .net_rx_valid(net_rx_valid), .net_rx_data(net_rx_data), .net_rx_ready(net_rx_ready),
    .net_tx_valid(net_tx_valid), .net_tx_data(net_tx_data), .net_tx_last(net_tx_last),
    .net_tx_ready(net_tx_ready), .rx_err(rx_err), .tx_overflow(tx_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic rx_push(input logic [15:0] w);
    int n;
    n = 0;
    net_rx_valid = 1'b1;
    net_rx_data  = w;
    while (!net_rx_ready && n < 50) begin
      tick();
      n++;
    end
    chk("rx_push_ready", net_rx_ready, 1);
    tick();
    net_rx_valid = 1'b0;
  endtask

  task automatic tx_push(input logic [15:0] w);
    gpp_trf_dp  = 1'b1;
    gpp_tx_data = w;
    tick();
    gpp_trf_dp  = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ram_out"}, RAM_rx_data_out, 0);
    chk({tag, "_flag"}, data_rx_flag, 0);
    chk({tag, "_trf_cp"}, gpp_trf_cp, 0);
    chk({tag, "_rx_ready"}, net_rx_ready, 0);
    chk({tag, "_tx_valid"}, net_tx_valid, 0);
    chk({tag, "_tx_data"}, net_tx_data, 0);
    chk({tag, "_tx_last"}, net_tx_last, 0);
    chk({tag, "_rx_err"}, rx_err, 0);
    chk({tag, "_tx_ovf"}, tx_overflow, 0);
  endtask

  // TX reference: a bounded queue of accepted words, each tagged with its
  // end-of-packet flag as the packet is framed on the way in.
  typedef struct packed {
    logic        last;
    logic [15:0] w;
  } beat_t;

  beat_t txq[$];
  int    in_rem = 0;
  logic  ovf_m  = 1'b0;

  always @(negedge clk) begin
    beat_t b;
    bit    pop_m;
    if (rst) begin
      txq.delete();
      in_rem = 0;
      ovf_m  = 1'b0;
    end else begin
      chk("tx_valid", net_tx_valid, txq.size() != 0);
      if (txq.size() != 0) begin
        chk("tx_data", net_tx_data, txq[0].w);
        chk("tx_last", net_tx_last, txq[0].last);
      end
      chk("tx_overflow", tx_overflow, ovf_m);
      pop_m = (txq.size() != 0) && net_tx_ready;
      if (pop_m) void'(txq.pop_front());
      if (gpp_trf_dp) begin
        if (txq.size() < TX_DEPTH) begin
          b.w = gpp_tx_data;
          if (in_rem == 0) in_rem = int'(gpp_tx_data[7:0]);
          else             in_rem = in_rem - 1;
          b.last = (in_rem == 0);
          txq.push_back(b);
        end else begin
          ovf_m = 1'b1;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  int          rn, gen_rem;
  logic        rtyp;
  logic [15:0] rhdr, rw;
  logic [15:0] rexp [RX_DEPTH];

  initial begin
    #1 rst = 1'b1;
    #1 chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    tick();
    chk("rx_ready_after_reset", net_rx_ready, 1);

    // Data packet delivery
    enable_rtr = 1'b1; gpp_rtr_dp = 1'b1;
    rx_push(16'h0003); rx_push(16'hAAAA); rx_push(16'hBBBB); rx_push(16'hCCCC);
    chk("dp_flag_one_edge", data_rx_flag, 0);
    chk("dp_rx_ready_busy", net_rx_ready, 0);
    tick();
    chk("dp_flag_two_edges", data_rx_flag, 1);
    chk("dp_trf_cp", gpp_trf_cp, 0);
    gpp_rx_addr = 6'd2; #1;
    chk("dp_read_addr2", RAM_rx_data_out, 16'hBBBB);
    enable_rtr = 1'b0;
    tick();
    chk("dp_release_flag", data_rx_flag, 0);
    chk("dp_release_ready", net_rx_ready, 1);
    chk("dp_release_ram_out", RAM_rx_data_out, 0);
    gpp_rtr_dp = 1'b0;

    // Type gating and strobe hold
    enable_rtr = 1'b1; gpp_rtr_dp = 1'b1;
    rx_push(16'h8001); rx_push(16'h1234);
    repeat (3) tick();
    chk("tg_wrong_strobe_flag", data_rx_flag, 0);
    chk("tg_wrong_strobe_ready", net_rx_ready, 0);
    gpp_rtr_cp = 1'b1;
    tick();
    chk("tg_flag", data_rx_flag, 1);
    chk("tg_trf_cp", gpp_trf_cp, 1);
    gpp_rx_addr = 6'd1; #1;
    chk("tg_read_addr1", RAM_rx_data_out, 16'h1234);
    gpp_rx_addr = 6'd0; #1;
    chk("tg_read_hdr", RAM_rx_data_out, 16'h8001);
    gpp_rtr_cp = 1'b0; gpp_rtr_dp = 1'b0;
    tick();
    chk("tg_strobe_hold", data_rx_flag, 1);
    enable_rtr = 1'b0;
    tick();
    chk("tg_release_flag", data_rx_flag, 0);
    chk("tg_release_cp", gpp_trf_cp, 0);

    // Oversize drop
    rx_push(16'h0050);
    chk("ov_rx_err", rx_err, 1);
    chk("ov_drop_ready", net_rx_ready, 1);
    for (int i = 0; i < 80; i++) rx_push(16'($urandom));
    chk("ov_no_flag", data_rx_flag, 0);
    enable_rtr = 1'b1; gpp_rtr_dp = 1'b1;
    rx_push(16'h0000);
    tick();
    chk("ov_next_flag", data_rx_flag, 1);
    chk("ov_next_hdr", RAM_rx_data_out, 16'h0000);
    chk("ov_err_sticky", rx_err, 1);
    enable_rtr = 1'b0; gpp_rtr_dp = 1'b0;
    tick();

    // TX framing
    net_tx_ready = 1'b0;
    tx_push(16'h0002); tx_push(16'h1111); tx_push(16'h2222);
    chk("tf_hdr_data", net_tx_data, 16'h0002);
    chk("tf_hdr_last", net_tx_last, 0);
    net_tx_ready = 1'b1;
    tick();
    chk("tf_p1_data", net_tx_data, 16'h1111);
    chk("tf_p1_last", net_tx_last, 0);
    tick();
    chk("tf_p2_data", net_tx_data, 16'h2222);
    chk("tf_p2_last", net_tx_last, 1);
    tick();
    chk("tf_drained", net_tx_valid, 0);
    net_tx_ready = 1'b0;
    tx_push(16'h8000);
    chk("tf_single_valid", net_tx_valid, 1);
    chk("tf_single_data", net_tx_data, 16'h8000);
    chk("tf_single_last", net_tx_last, 1);
    net_tx_ready = 1'b1;
    tick();
    chk("tf_single_drained", net_tx_valid, 0);

    // Overflow: full + simultaneous pop accepts, full alone drops
    net_tx_ready = 1'b0;
    for (int i = 0; i < TX_DEPTH; i++) tx_push(16'(i << 8));
    chk("of_full_no_ovf", tx_overflow, 0);
    net_tx_ready = 1'b1;
    tx_push(16'h5500);
    chk("of_pop_push_no_ovf", tx_overflow, 0);
    net_tx_ready = 1'b0;
    tx_push(16'h6600);
    chk("of_ovf_set", tx_overflow, 1);
    net_tx_ready = 1'b1;
    repeat (20) tick();
    chk("of_drained", net_tx_valid, 0);

    // Reset mid-RX with a TX word pending
    net_tx_ready = 1'b0;
    rx_push(16'h0004); rx_push(16'h0101); rx_push(16'h0202);
    tx_push(16'h0000);
    rst = 1'b1;
    #1 chk_all_zero("mid_reset");
    @(posedge clk);
    #2 rst = 1'b0;
    tick();
    chk("mr_rx_ready", net_rx_ready, 1);
    enable_rtr = 1'b1; gpp_rtr_dp = 1'b1;
    rx_push(16'h0000);
    tick();
    chk("mr_fresh_flag", data_rx_flag, 1);
    enable_rtr = 1'b0; gpp_rtr_dp = 1'b0;
    tick();

    // Randomized RX packets against a stored copy of each payload
    for (int p = 0; p < 20; p++) begin
      rn   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(64, 100)) : int'($urandom_range(0, 63));
      rtyp = 1'($urandom_range(0, 1));
      rhdr = {rtyp, 7'($urandom), 8'(rn)};
      enable_rtr = 1'b1;
      gpp_rtr_cp = !rtyp; gpp_rtr_dp = rtyp;
      rx_push(rhdr);
      if (rn < RX_DEPTH) rexp[0] = rhdr;
      for (int i = 1; i <= rn; i++) begin
        rw = 16'($urandom);
        if (rn < RX_DEPTH) rexp[i] = rw;
        rx_push(rw);
      end
      if (rn >= RX_DEPTH) begin
        chk("rr_drop_err", rx_err, 1);
        chk("rr_drop_ready", net_rx_ready, 1);
        chk("rr_drop_flag", data_rx_flag, 0);
      end else begin
        tick();
        chk("rr_gated_flag", data_rx_flag, 0);
        gpp_rtr_cp = rtyp; gpp_rtr_dp = !rtyp;
        tick();
        chk("rr_flag", data_rx_flag, 1);
        chk("rr_trf_cp", gpp_trf_cp, rtyp);
        for (int a = 0; a <= rn; a++) begin
          gpp_rx_addr = 6'(a); #1;
          chk("rr_read", RAM_rx_data_out, rexp[a]);
        end
        enable_rtr = 1'b0;
        tick();
        chk("rr_release", data_rx_flag, 0);
      end
      enable_rtr = 1'b0; gpp_rtr_cp = 1'b0; gpp_rtr_dp = 1'b0;
    end

    // Randomized TX traffic; the negedge reference checks every cycle
    gen_rem = 0;
    for (int k = 0; k < 400; k++) begin
      net_tx_ready = ($urandom_range(0, 9) < ((k < 200) ? 3 : 7));
      gpp_trf_dp   = 1'($urandom_range(0, 1));
      if (gen_rem == 0) begin
        gpp_tx_data = {1'($urandom), 7'($urandom), 8'($urandom_range(0, 4))};
        if (gpp_trf_dp) gen_rem = int'(gpp_tx_data[7:0]);
      end else begin
        gpp_tx_data = 16'($urandom);
        if (gpp_trf_dp) gen_rem--;
      end
      tick();
    end
    gpp_trf_dp = 1'b0; net_tx_ready = 1'b1;
    repeat (20) tick();
    chk("rt_drained", net_tx_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
